fir_cfg_master: RTL and testbench

FIR_CFG_MASTER -- requirements
Module: fir_cfg_master

---
 rtl/fir_pkg.sv | 38 +++
 rtl/fir_cfg_master_if.sv | 31 +++
 rtl/fir_axil_xfer.sv | 111 +++++++++++
 rtl/fir_cfg_master.sv | 148 ++++++++++++++
 tb/tb_fir_cfg_master.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and register map for the FIR configuration master.
package fir_pkg;

  // Sequencing FSM: program length, program taps, read taps back, kick off, poll.
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WR_LEN        = 3'd1,
    WR_TAP        = 3'd2,
    RD_TAP        = 3'd3,
    WR_START      = 3'd4,
    POLL_GAP_WAIT = 3'd5,
    POLL_RD       = 3'd6,
    FINISH        = 3'd7
  } fir_state_e;

  // Single-transaction engine states.
  typedef enum logic [1:0] {
    X_IDLE  = 2'd0,
    X_WRITE = 2'd1,
    X_RADDR = 2'd2,
    X_RDATA = 2'd3
  } xfer_state_e;

  // Register offsets in the FIR slave.
  localparam int unsigned REG_AP_CTRL  = 32'h00;
  localparam int unsigned REG_DATA_LEN = 32'h10;
  localparam int unsigned REG_TAP_BASE = 32'h20;

  // ap_done lives in bit 1 of AP_CTRL; writing 1 sets ap_start.
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_START_VAL = 32'h1;

  // Byte offset of coefficient k.
  function automatic int unsigned tap_offset(input logic [3:0] idx);
    return REG_TAP_BASE + (32'(idx) << 2);
  endfunction

endpackage

// File: rtl/fir_cfg_master_if.sv
// AXI-Lite bus between the configuration master and the FIR slave.
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high; the source keeps valid and its
// payload stable until that edge and may drop valid only afterwards.
interface fir_cfg_master_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   awready;
  logic                   wvalid;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   wready;
  logic                   arvalid;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   arready;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_axil_xfer.sv
// Runs one AXI-Lite write or read per start request and pulses ack when done.
module fir_axil_xfer
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic                   is_write,
  input  logic [pADDR_WIDTH-1:0] addr,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   idle,
  output logic                   ack,
  output logic [pDATA_WIDTH-1:0] rd_data,
  output xfer_state_e            state_dbg,
  fir_cfg_master_if.master       bus
);

  xfer_state_e state_q, state_d;
  logic        aw_seen_q, w_seen_q;
  logic        aw_hs, w_hs, wr_complete;

  // A write finishes once both address and data handshakes have happened,
  // in either order or together.
  assign aw_hs       = bus.awvalid & bus.awready;
  assign w_hs        = bus.wvalid & bus.wready;
  assign wr_complete = (aw_seen_q | aw_hs) & (w_seen_q | w_hs);
  assign idle        = (state_q == X_IDLE);
  assign state_dbg   = state_q;

  // State register.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state_q <= X_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      X_IDLE:  if (start) state_d = is_write ? X_WRITE : X_RADDR;
      X_WRITE: if (wr_complete) state_d = X_IDLE;
      X_RADDR: if (bus.arready) state_d = X_RDATA;
      X_RDATA: if (bus.rvalid) state_d = X_IDLE;
      default: state_d = X_IDLE;
    endcase
  end

  // Bus drivers: valids rise on start and fall the cycle after their handshake.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      bus.awvalid <= 1'b0;
      bus.awaddr  <= '0;
      bus.wvalid  <= 1'b0;
      bus.wdata   <= '0;
      bus.arvalid <= 1'b0;
      bus.araddr  <= '0;
      bus.rready  <= 1'b0;
      aw_seen_q   <= 1'b0;
      w_seen_q    <= 1'b0;
      ack         <= 1'b0;
      rd_data     <= '0;
    end else begin
      ack <= 1'b0;
      case (state_q)
        X_IDLE: begin
          if (start && is_write) begin
            bus.awvalid <= 1'b1;
            bus.wvalid  <= 1'b1;
            bus.awaddr  <= addr;
            bus.wdata   <= wdata;
            aw_seen_q   <= 1'b0;
            w_seen_q    <= 1'b0;
          end else if (start) begin
            bus.arvalid <= 1'b1;
            bus.araddr  <= addr;
          end
        end
        X_WRITE: begin
          if (aw_hs) begin
            bus.awvalid <= 1'b0;
            aw_seen_q   <= 1'b1;
          end
          if (w_hs) begin
            bus.wvalid <= 1'b0;
            w_seen_q   <= 1'b1;
          end
          if (wr_complete) ack <= 1'b1;
        end
        X_RADDR: begin
          // rready only rises after arvalid has dropped, so the two never overlap.
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
          end
        end
        X_RDATA: begin
          if (bus.rvalid) begin
            bus.rready <= 1'b0;
            rd_data    <= bus.rdata;
            ack        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_cfg_master.sv
// Programs a FIR block over AXI-Lite: length, taps, tap readback check,
// ap_start, then polls ap_done. POLL_GAP must be at least 1.
module fir_cfg_master
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_GAP    = 4
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  input  logic                  cfg_start,
  input  logic [31:0]           data_len,
  input  logic [Tape_Num*32-1:0] tap_coef,
  fir_cfg_master_if.master      m_axil,
  output logic                  busy,
  output logic                  done,
  output logic                  verify_err,
  output fir_state_e            state_dbg,
  output xfer_state_e           xfer_dbg
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  fir_state_e              state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [31:0]             len_q;
  logic [Tape_Num*32-1:0]  taps_q;
  logic [31:0]             tap_word;
  logic                    last_tap;

  logic                    x_start, x_write, x_idle, x_ack;
  logic [pADDR_WIDTH-1:0]  x_addr;
  logic [pDATA_WIDTH-1:0]  x_wdata, x_rdata;

  assign tap_word  = taps_q[32*int'(idx_q) +: 32];
  assign last_tap  = (idx_q == 4'(Tape_Num - 1));
  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign done      = (state_q == FINISH);
  assign state_dbg = state_q;

  fir_axil_xfer #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_xfer (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .start     (x_start),
    .is_write  (x_write),
    .addr      (x_addr),
    .wdata     (x_wdata),
    .idle      (x_idle),
    .ack       (x_ack),
    .rd_data   (x_rdata),
    .state_dbg (xfer_dbg),
    .bus       (m_axil)
  );

  // State, tap index and poll-gap counter registers.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // Next state and transaction request; a new transfer is requested only
  // when the engine is idle and not in its ack cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    x_start = 1'b0;
    x_write = 1'b0;
    x_addr  = '0;
    x_wdata = '0;
    case (state_q)
      IDLE: if (cfg_start) state_d = WR_LEN;
      WR_LEN: begin
        x_start = x_idle & ~x_ack;
        x_write = 1'b1;
        x_addr  = pADDR_WIDTH'(REG_DATA_LEN);
        x_wdata = pDATA_WIDTH'(len_q);
        if (x_ack) state_d = WR_TAP;
      end
      WR_TAP: begin
        x_start = x_idle & ~x_ack;
        x_write = 1'b1;
        x_addr  = pADDR_WIDTH'(tap_offset(idx_q));
        x_wdata = pDATA_WIDTH'(tap_word);
        if (x_ack && last_tap) state_d = RD_TAP;
        else if (x_ack)        idx_d   = idx_q + 4'd1;
      end
      RD_TAP: begin
        x_start = x_idle & ~x_ack;
        x_addr  = pADDR_WIDTH'(tap_offset(idx_q));
        if (x_ack && last_tap) state_d = WR_START;
        else if (x_ack)        idx_d   = idx_q + 4'd1;
      end
      WR_START: begin
        x_start = x_idle & ~x_ack;
        x_write = 1'b1;
        x_addr  = pADDR_WIDTH'(REG_AP_CTRL);
        x_wdata = pDATA_WIDTH'(AP_START_VAL);
        if (x_ack) state_d = POLL_GAP_WAIT;
      end
      POLL_GAP_WAIT: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = POLL_RD;
        else                               gap_d   = gap_q + 1'b1;
      end
      POLL_RD: begin
        x_start = x_idle & ~x_ack;
        x_addr  = pADDR_WIDTH'(REG_AP_CTRL);
        if (x_ack) state_d = x_rdata[AP_DONE_BIT] ? FINISH : POLL_GAP_WAIT;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counters restart from zero on every state change.
    if (state_d != state_q) begin
      idx_d = '0;
      gap_d = '0;
    end
  end

  // Capture the request and track readback mismatches (sticky per run).
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      len_q      <= '0;
      taps_q     <= '0;
      verify_err <= 1'b0;
    end else if (state_q == IDLE && cfg_start) begin
      len_q      <= data_len;
      taps_q     <= tap_coef;
      verify_err <= 1'b0;
    end else if (state_q == RD_TAP && x_ack && x_rdata != pDATA_WIDTH'(tap_word)) begin
      verify_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_cfg_master.sv
// Bench for fir_cfg_master: AXI-Lite slave responder, expected-transaction
// scoreboard and a bus monitor that checks every completed transfer.
module tb_fir_cfg_master;
  import fir_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;
  localparam int PG = 4;
  localparam int IW = 2 + AW + DW;

  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_RD   = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic axis_clk = 1'b0;
  logic axis_rst;
  always #5 axis_clk = ~axis_clk;

  logic              cfg_start;
  logic [31:0]       data_len;
  logic [NT*32-1:0]  tap_coef;
  logic              busy, done, verify_err;
  fir_state_e        state_dbg;
  xfer_state_e       xfer_dbg;

  fir_cfg_master_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_cfg_master #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .Tape_Num    (NT),
    .POLL_GAP    (PG)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .cfg_start  (cfg_start),
    .data_len   (data_len),
    .tap_coef   (tap_coef),
    .m_axil     (bus),
    .busy       (busy),
    .done       (done),
    .verify_err (verify_err),
    .state_dbg  (state_dbg),
    .xfer_dbg   (xfer_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [IW-1:0] exp_q[$];
  logic [31:0]   taps[NT];

  function automatic logic [IW-1:0] mk(input logic [1:0] k, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    return {k, a, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic sb_compare(input string name, input logic [IW-1:0] got);
    logic [IW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected kind=%0d addr=%0h data=%0h", name,
               got[IW-1 -: 2], got[DW +: AW], got[DW-1:0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        bad++;
        $display("FAIL %s actual kind=%0d addr=%0h data=%0h required kind=%0d addr=%0h data=%0h",
                 name, got[IW-1 -: 2], got[DW +: AW], got[DW-1:0],
                 e[IW-1 -: 2], e[DW +: AW], e[DW-1:0]);
      end
    end
  endtask

  // ---------------- slave responder ----------------
  int aw_delay = 0, w_delay = 0, done_poll = 1, corrupt_tap = -1;
  int poll_cnt = 0;
  logic [31:0] mem[256];

  initial begin
    int aw_cnt, w_cnt;
    logic s_aw, s_w, s_ar, s_r, wa_got, wd_got;
    logic [AW-1:0] s_awaddr, s_araddr, wa;
    logic [DW-1:0] s_wdata, wd;
    aw_cnt = 0; w_cnt = 0; wa_got = 0; wd_got = 0; wa = '0; wd = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.rvalid  = 1'b0; bus.rdata  = '0;
    forever begin
      @(negedge axis_clk);
      s_aw = bus.awvalid && bus.awready;
      s_w  = bus.wvalid && bus.wready;
      s_ar = bus.arvalid && bus.arready;
      s_r  = bus.rvalid && bus.rready;
      s_awaddr = bus.awaddr; s_wdata = bus.wdata; s_araddr = bus.araddr;
      @(posedge axis_clk);
      #1;
      if (axis_rst) begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; wa_got = 0; wd_got = 0;
        continue;
      end
      if (s_aw) begin wa = s_awaddr; wa_got = 1; end
      if (s_w)  begin wd = s_wdata;  wd_got = 1; end
      if (wa_got && wd_got) begin
        mem[wa[9:2]] = wd;
        wa_got = 0; wd_got = 0;
      end
      if (bus.awvalid && !s_aw) begin
        bus.awready = (aw_cnt >= aw_delay);
        if (aw_cnt < aw_delay) aw_cnt++;
      end else begin
        bus.awready = 1'b0; aw_cnt = 0;
      end
      if (bus.wvalid && !s_w) begin
        bus.wready = (w_cnt >= w_delay);
        if (w_cnt < w_delay) w_cnt++;
      end else begin
        bus.wready = 1'b0; w_cnt = 0;
      end
      bus.arready = bus.arvalid && !s_ar;
      if (s_r) bus.rvalid = 1'b0;
      if (s_ar) begin
        bus.rvalid = 1'b1;
        if (s_araddr == '0) begin
          poll_cnt++;
          bus.rdata = (poll_cnt >= done_poll) ? 32'h2 : 32'h0;
        end else if (corrupt_tap >= 0 && 32'(s_araddr) == 32'h20 + 4*corrupt_tap) begin
          bus.rdata = 32'd99;
        end else begin
          bus.rdata = mem[s_araddr[9:2]];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic aw_got, w_got, poll_armed, prev_ar;
    logic [AW-1:0] m_wa, m_ra;
    logic [DW-1:0] m_wd;
    int idle_run;
    aw_got = 0; w_got = 0; poll_armed = 0; prev_ar = 0; idle_run = 0;
    m_wa = '0; m_ra = '0; m_wd = '0;
    forever begin
      @(negedge axis_clk);
      if (axis_rst) begin
        aw_got = 0; w_got = 0; poll_armed = 0; prev_ar = 0; idle_run = 0;
        continue;
      end
      if (bus.arvalid && bus.rready) check("ar_rready_overlap", 1, 0);
      if (bus.arvalid && !prev_ar && bus.araddr == '0 && poll_armed)
        check("poll_gap_ok", 64'(idle_run >= PG), 1);
      if (bus.awvalid && bus.awready) begin m_wa = bus.awaddr; aw_got = 1; end
      if (bus.wvalid && bus.wready)   begin m_wd = bus.wdata;  w_got  = 1; end
      if (aw_got && w_got) begin
        sb_compare("write", mk(K_WR, m_wa, m_wd));
        aw_got = 0; w_got = 0;
      end
      if (bus.arvalid && bus.arready) m_ra = bus.araddr;
      if (bus.rvalid && bus.rready) begin
        sb_compare("read", mk(K_RD, m_ra, bus.rdata));
        if (m_ra == '0) poll_armed = 1;
      end
      if (done) begin
        sb_compare("done", mk(K_DONE, '0, {31'b0, verify_err}));
        check("busy_at_done", 64'(busy), 0);
        done_cnt++;
        poll_armed = 0;
      end
      if (bus.awvalid || bus.wvalid || bus.arvalid || bus.rready) idle_run = 0;
      else idle_run++;
      prev_ar = bus.arvalid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_resp(input int awd, input int wd, input int polls, input int corrupt);
    aw_delay = awd; w_delay = wd; done_poll = polls; corrupt_tap = corrupt; poll_cnt = 0;
  endtask

  task automatic push_expected(input logic [31:0] len, input int corrupt, input int polls,
                               input int upto);
    exp_q.push_back(mk(K_WR, 12'h010, len));
    for (int k = 0; k < ((upto < 0) ? NT : upto); k++)
      exp_q.push_back(mk(K_WR, AW'(32'h20 + 4*k), taps[k]));
    if (upto >= 0) return;
    for (int k = 0; k < NT; k++)
      exp_q.push_back(mk(K_RD, AW'(32'h20 + 4*k), (k == corrupt) ? 32'd99 : taps[k]));
    exp_q.push_back(mk(K_WR, 12'h000, 32'h1));
    for (int p = 1; p <= polls; p++)
      exp_q.push_back(mk(K_RD, 12'h000, (p == polls) ? 32'h2 : 32'h0));
    exp_q.push_back(mk(K_DONE, '0, (corrupt >= 0) ? 32'h1 : 32'h0));
  endtask

  task automatic start_cfg(input logic [31:0] len);
    @(negedge axis_clk);
    data_len = len;
    for (int k = 0; k < NT; k++) tap_coef[32*k +: 32] = taps[k];
    cfg_start = 1'b1;
    @(negedge axis_clk);
    cfg_start = 1'b0;
    check("busy_after_start", 64'(busy), 1);
    check("verr_cleared", 64'(verify_err), 0);
  endtask

  task automatic wait_done(input string name);
    int start_cnt;
    start_cnt = done_cnt;
    for (int i = 0; i < 2000; i++) begin
      @(negedge axis_clk);
      if (done_cnt > start_cnt) break;
    end
    check({name, "_done_seen"}, 64'(done_cnt > start_cnt), 1);
    repeat (3) @(negedge axis_clk);
    check({name, "_queue_drained"}, 64'(exp_q.size()), 0);
  endtask

  task automatic check_bus_zero(input string name);
    check({name, "_awvalid"}, 64'(bus.awvalid), 0);
    check({name, "_wvalid"},  64'(bus.wvalid), 0);
    check({name, "_arvalid"}, 64'(bus.arvalid), 0);
    check({name, "_rready"},  64'(bus.rready), 0);
    check({name, "_busy"},    64'(busy), 0);
    check({name, "_done"},    64'(done), 0);
    check({name, "_verr"},    64'(verify_err), 0);
    check({name, "_awaddr"},  64'(bus.awaddr), 0);
    check({name, "_araddr"},  64'(bus.araddr), 0);
    check({name, "_wdata"},   64'(bus.wdata), 0);
    check({name, "_state"},   64'(state_dbg), 64'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tv[NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    bit found;
    int dc;
    for (int k = 0; k < NT; k++) taps[k] = tv[k];
    for (int i = 0; i < 256; i++) mem[i] = '0;
    axis_rst = 1'b1; cfg_start = 1'b0; data_len = '0; tap_coef = '0;
    repeat (3) @(negedge axis_clk);
    check_bus_zero("reset");
    axis_rst = 1'b0;
    repeat (2) @(negedge axis_clk);
    check_bus_zero("post_reset");

    // Basic run, zero-wait responder.
    set_resp(0, 0, 1, -1);
    push_expected(32'd600, -1, 1, -1);
    start_cfg(32'd600);
    wait_done("basic");

    // Address accepted three cycles before data on each write.
    set_resp(0, 3, 1, -1);
    push_expected(32'd600, -1, 1, -1);
    start_cfg(32'd600);
    wait_done("slow_wready");

    // Tap 5 reads back wrong: error is sticky, run still completes.
    set_resp(0, 0, 1, 5);
    push_expected(32'd77, 5, 1, -1);
    start_cfg(32'd77);
    wait_done("corrupt");
    repeat (5) @(negedge axis_clk);
    check("verr_sticky", 64'(verify_err), 1);

    // ap_done only on the third poll.
    set_resp(0, 0, 3, -1);
    push_expected(32'd1234, -1, 3, -1);
    start_cfg(32'd1234);
    wait_done("three_polls");

    // Reset in the middle of writing tap 7, then restart.
    set_resp(0, 0, 1, -1);
    push_expected(32'd600, -1, 1, 7);
    start_cfg(32'd600);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge axis_clk);
      #2;
      if (bus.awvalid && bus.awaddr == 12'h03C) begin found = 1; break; end
    end
    check("tap7_reached", 64'(found), 1);
    axis_rst = 1'b1;
    #1;
    check_bus_zero("midrun_reset");
    check("midrun_queue", 64'(exp_q.size()), 0);
    @(negedge axis_clk);
    cfg_start = 1'b1;
    @(negedge axis_clk);
    cfg_start = 1'b0;
    @(negedge axis_clk);
    axis_rst = 1'b0;
    repeat (3) @(negedge axis_clk);
    check("start_in_reset_ignored", 64'(busy), 0);
    push_expected(32'd600, -1, 1, -1);
    start_cfg(32'd600);
    wait_done("restart");

    // Second cfg_start while busy must be ignored.
    set_resp(0, 0, 1, -1);
    push_expected(32'd42, -1, 1, -1);
    start_cfg(32'd42);
    dc = done_cnt;
    repeat (20) @(negedge axis_clk);
    data_len = 32'd999;
    cfg_start = 1'b1;
    @(negedge axis_clk);
    cfg_start = 1'b0;
    wait_done("busy_start");
    repeat (30) @(negedge axis_clk);
    check("single_done", 64'(done_cnt - dc), 1);
    check("no_extra_txn", 64'(exp_q.size()), 0);
    check("idle_after", 64'(state_dbg), 64'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
